// File: rtl/mux4_ser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux4_ser_pkg
// Description : Shared types and helpers for the mux4_serializer block:
//               frame state encoding, step count and hold-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package mux4_ser_pkg;

   // Frame sequencer states; PARITY is only reachable with MUX4_SER_PARITY_EN
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_PARITY = 2'd2
   } state_e;

   // One step per mux data input
   localparam int NUM_STEPS = 4;

   // Width of a modulo-hold counter; never narrower than one bit
   function automatic int hold_cnt_width(input int hold);
      return (hold <= 1) ? 1 : $clog2(hold);
   endfunction

endpackage : mux4_ser_pkg
`default_nettype wire

// File: rtl/mux4_serializer_hold_counter.sv
`default_nettype none
// ============================================================================
// Module      : hold_counter
// Description : Modulo-HOLD_CYCLES counter with synchronous clear. Reports
//               terminal count for the current cycle and for the next one so
//               the parent can register frame strobes one cycle ahead.
// Revision    : 1.0 - initial release
// ============================================================================
module hold_counter
   import mux4_ser_pkg::*;
#(
   parameter int HOLD_CYCLES = 1
)(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc,
   output logic tc_next
);

   localparam int              c_width = hold_cnt_width(HOLD_CYCLES);
   localparam logic [c_width-1:0] c_max = c_width'(HOLD_CYCLES - 1);

   logic [c_width-1:0] cnt_q;
   logic [c_width-1:0] cnt_d;

   // Next count: clear wins, otherwise wrap at the terminal value
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == c_max) ? '0 : cnt_q + c_width'(1);
      end
   end

   // Count register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc      = (cnt_q == c_max);
   assign tc_next = (cnt_d == c_max);

endmodule : hold_counter
`default_nettype wire

// File: rtl/mux4_serializer.sv
`default_nettype none
// ============================================================================
// Module      : mux4_serializer
// Description : Accepts a 4-bit word over valid/ready, presents it on the four
//               data inputs of a 4:1 mux and steps the select 00..11 (each
//               held HOLD_CYCLES cycles) so the mux emits the word LSB first.
//               Optional macro MUX4_SER_PARITY_EN appends an even-parity step
//               and adds the parity_out port.
// Revision    : 1.0 - initial release
// ============================================================================
module mux4_serializer
   import mux4_ser_pkg::*;
#(
   parameter int         HOLD_CYCLES = 1,
   parameter logic [1:0] IDLE_SEL    = 2'b00
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_data,
   output logic       data1,
   output logic       data2,
   output logic       data3,
   output logic       data4,
   output logic [1:0] sel,
   output logic       out_valid,
   output logic       out_last,
   output logic       busy
`ifdef MUX4_SER_PARITY_EN
   ,
   output logic       parity_out
`endif
);

   localparam logic [1:0] c_last_step = 2'(NUM_STEPS - 1);

   state_e     state_q, state_d;
   logic [1:0] step_q, step_d;
   logic [3:0] data_q, data_d;
   logic [1:0] sel_q, sel_d;
   logic       busy_q, busy_d;
   logic       out_last_q, out_last_d;
   logic       parity_q, parity_d;

   logic       w_cnt_clr;
   logic       w_cnt_en;
   logic       w_cnt_tc;
   logic       w_cnt_tc_next;
   logic       w_last_step;
   logic       w_frame_end;
   logic       w_accept;

   hold_counter #(
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_hold_counter (
      .clk     (clk),
      .rst     (rst),
      .clr     (w_cnt_clr),
      .en      (w_cnt_en),
      .tc      (w_cnt_tc),
      .tc_next (w_cnt_tc_next)
   );

   assign w_last_step = (step_q == c_last_step);

`ifdef MUX4_SER_PARITY_EN
   assign w_frame_end = (state_q == ST_PARITY) && w_cnt_tc;
`else
   assign w_frame_end = (state_q == ST_SHIFT) && w_last_step && w_cnt_tc;
`endif

   // Ready depends only on state and counter, so it cannot loop through in_valid
   assign in_ready = !rst && ((state_q == ST_IDLE) || w_frame_end);
   assign w_accept = in_valid && in_ready;

   // Next-state and next-output decode; outputs are computed from the next
   // state so every strobe leaves the block from a flop
   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      w_cnt_clr = 1'b0;
      w_cnt_en  = 1'b0;
      data_d    = w_accept ? in_data : data_q;

      case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
               state_d   = ST_SHIFT;
               step_d    = 2'd0;
               w_cnt_clr = 1'b1;
            end
         end
         ST_SHIFT: begin
            w_cnt_en = 1'b1;
            if (w_cnt_tc) begin
               step_d = step_q + 2'd1;
               if (w_last_step) begin
`ifdef MUX4_SER_PARITY_EN
                  state_d = ST_PARITY;
`else
                  // Back-to-back accept restarts at step 0 with no idle gap
                  if (w_accept) begin
                     state_d   = ST_SHIFT;
                     step_d    = 2'd0;
                     w_cnt_clr = 1'b1;
                  end else begin
                     state_d = ST_IDLE;
                  end
`endif
               end
            end
         end
`ifdef MUX4_SER_PARITY_EN
         ST_PARITY: begin
            w_cnt_en = 1'b1;
            if (w_cnt_tc) begin
               step_d = 2'd0;
               if (w_accept) begin
                  state_d   = ST_SHIFT;
                  w_cnt_clr = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d     = (state_d != ST_IDLE);
      sel_d      = IDLE_SEL;
      out_last_d = 1'b0;
      parity_d   = 1'b0;
      if (state_d == ST_SHIFT) begin
         sel_d = step_d;
`ifndef MUX4_SER_PARITY_EN
         out_last_d = (step_d == c_last_step) && w_cnt_tc_next;
`endif
      end
`ifdef MUX4_SER_PARITY_EN
      if (state_d == ST_PARITY) begin
         sel_d      = 2'b11;
         out_last_d = w_cnt_tc_next;
         parity_d   = ^data_d;
      end
`endif
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         step_q     <= 2'd0;
         data_q     <= 4'd0;
         sel_q      <= IDLE_SEL;
         busy_q     <= 1'b0;
         out_last_q <= 1'b0;
         parity_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         data_q     <= data_d;
         sel_q      <= sel_d;
         busy_q     <= busy_d;
         out_last_q <= out_last_d;
         parity_q   <= parity_d;
      end
   end

   assign data1     = data_q[0];
   assign data2     = data_q[1];
   assign data3     = data_q[2];
   assign data4     = data_q[3];
   assign sel       = sel_q;
   assign busy      = busy_q;
   assign out_valid = busy_q;
   assign out_last  = out_last_q;

`ifdef MUX4_SER_PARITY_EN
   assign parity_out = parity_q;
`else
   // Parity flop stays constant 0 in this build and is optimised away
   logic w_unused_parity;
   assign w_unused_parity = parity_q;
`endif

endmodule : mux4_serializer
`default_nettype wire

// File: tb/tb_mux4_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux4_serializer
// Description : Directed self-checking bench for mux4_serializer. Two
//               instances: HOLD_CYCLES=1/IDLE_SEL=00 and HOLD_CYCLES=3/
//               IDLE_SEL=01. Honours MUX4_SER_PARITY_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux4_serializer;

`ifdef MUX4_SER_PARITY_EN
   localparam int c_steps = 5;
`else
   localparam int c_steps = 4;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   // Instance A: HOLD_CYCLES = 1
   logic       a_in_valid = 1'b1;
   logic [3:0] a_in_data  = 4'hF;
   logic       a_in_ready, a_d1, a_d2, a_d3, a_d4, a_out_valid, a_out_last, a_busy;
   logic [1:0] a_sel;
   logic       a_parity;

   // Instance B: HOLD_CYCLES = 3, IDLE_SEL = 01
   logic       b_in_valid = 1'b1;
   logic [3:0] b_in_data  = 4'hF;
   logic       b_in_ready, b_d1, b_d2, b_d3, b_d4, b_out_valid, b_out_last, b_busy;
   logic [1:0] b_sel;
   logic       b_parity;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mux4_serializer #(.HOLD_CYCLES(1), .IDLE_SEL(2'b00)) u_dut_a (
      .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_data(a_in_data), .data1(a_d1), .data2(a_d2), .data3(a_d3), .data4(a_d4),
      .sel(a_sel), .out_valid(a_out_valid), .out_last(a_out_last), .busy(a_busy)
`ifdef MUX4_SER_PARITY_EN
      , .parity_out(a_parity)
`endif
   );

   mux4_serializer #(.HOLD_CYCLES(3), .IDLE_SEL(2'b01)) u_dut_b (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data(b_in_data), .data1(b_d1), .data2(b_d2), .data3(b_d3), .data4(b_d4),
      .sel(b_sel), .out_valid(b_out_valid), .out_last(b_out_last), .busy(b_busy)
`ifdef MUX4_SER_PARITY_EN
      , .parity_out(b_parity)
`endif
   );

`ifndef MUX4_SER_PARITY_EN
   assign a_parity = 1'b0;
   assign b_parity = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference 4:1 mux fed by the DUT's data outputs
   function automatic logic mux_ref(input logic [3:0] d, input logic [1:0] s);
      return d[s];
   endfunction

   function automatic logic [3:0] a_word();
      return {a_d4, a_d3, a_d2, a_d1};
   endfunction

   // Walks one instance-A frame starting the cycle after its accept edge.
   // On the final cycle, optionally offers the next word back-to-back.
   task automatic frame_a(input logic [3:0] w, input logic [3:0] nxt, input bit b2b);
      logic [3:0] ww;
      ww = w;
      for (int c = 0; c < c_steps; c++) begin
         check("a_sel",      a_sel, (c < 4) ? c : 3);
         check("a_data",     a_word(), ww);
         check("a_valid",    a_out_valid, 1);
         check("a_busy",     a_busy, 1);
         check("a_last",     a_out_last, (c == c_steps - 1));
         check("a_ready",    a_in_ready, (c == c_steps - 1));
         if (c < 4) check("a_stream", mux_ref(a_word(), a_sel), ww[c]);
         check("a_parity",   a_parity, (c == 4) ? ^ww : 1'b0);
         if (c == c_steps - 1) begin
            if (b2b) begin
               a_in_data  = nxt;
               a_in_valid = 1'b1;
            end else begin
               a_in_valid = 1'b0;
            end
         end
         tick();
      end
      a_in_valid = 1'b0;
   endtask

   initial begin
      logic [3:0] bw;

      // Reset held two cycles while both sources offer data
      for (int i = 0; i < 2; i++) begin
         tick();
         check("rst_a_ready", a_in_ready, 0);
         check("rst_a_out",   {a_word(), a_out_valid, a_out_last, a_busy, a_parity}, 0);
         check("rst_a_sel",   a_sel, 2'b00);
         check("rst_b_ready", b_in_ready, 0);
         check("rst_b_sel",   b_sel, 2'b01);
         check("rst_b_out",   {b_d4, b_d3, b_d2, b_d1, b_out_valid, b_out_last, b_busy}, 0);
      end
      rst        = 1'b0;
      a_in_valid = 1'b0;
      b_in_valid = 1'b0;
      #1;
      check("post_rst_a_ready", a_in_ready, 1);
      check("post_rst_b_ready", b_in_ready, 1);

      // Single frame 1010
      a_in_data  = 4'b1010;
      a_in_valid = 1'b1;
      tick();
      a_in_valid = 1'b0;
      frame_a(4'b1010, 4'b0000, 0);
      check("idle_valid", a_out_valid, 0);
      check("idle_busy",  a_busy, 0);
      check("idle_sel",   a_sel, 2'b00);
      check("idle_hold",  a_word(), 4'b1010);
      check("idle_ready", a_in_ready, 1);

      // Back-to-back 0011 then 1100 offered on the last cycle
      a_in_data  = 4'b0011;
      a_in_valid = 1'b1;
      tick();
      a_in_valid = 1'b0;
      frame_a(4'b0011, 4'b1100, 1);
      frame_a(4'b1100, 4'b0000, 0);
      check("b2b_end_valid", a_out_valid, 0);

      // Reset in the middle of a frame at step 2
      a_in_data  = 4'b1001;
      a_in_valid = 1'b1;
      tick();
      a_in_valid = 1'b0;
      tick();
      tick();
      check("mid_sel2", a_sel, 2'd2);
      rst = 1'b1;
      tick();
      check("mid_rst_valid", a_out_valid, 0);
      check("mid_rst_last",  a_out_last, 0);
      check("mid_rst_sel",   a_sel, 2'b00);
      check("mid_rst_data",  a_word(), 0);
      check("mid_rst_ready", a_in_ready, 0);
      rst = 1'b0;
      #1;
      check("mid_ready_back", a_in_ready, 1);
      a_in_data  = 4'b0110;
      a_in_valid = 1'b1;
      tick();
      a_in_valid = 1'b0;
      frame_a(4'b0110, 4'b0000, 0);

`ifdef MUX4_SER_PARITY_EN
      // Parity frames: odd and even weight words
      a_in_data  = 4'b0111;
      a_in_valid = 1'b1;
      tick();
      a_in_valid = 1'b0;
      frame_a(4'b0111, 4'b0000, 0);
      a_in_data  = 4'b0101;
      a_in_valid = 1'b1;
      tick();
      a_in_valid = 1'b0;
      frame_a(4'b0101, 4'b0000, 0);
`endif

      // Instance B: each select held three cycles
      bw         = 4'b0110;
      b_in_data  = bw;
      b_in_valid = 1'b1;
      tick();
      b_in_valid = 1'b0;
      for (int c = 0; c < 3 * c_steps; c++) begin
         check("b_sel",   b_sel, (c / 3 < 4) ? (c / 3) : 3);
         check("b_valid", b_out_valid, 1);
         check("b_last",  b_out_last, (c == 3 * c_steps - 1));
         check("b_ready", b_in_ready, (c == 3 * c_steps - 1));
         if (c / 3 < 4) check("b_stream", mux_ref({b_d4, b_d3, b_d2, b_d1}, b_sel), bw[c / 3]);
         check("b_parity", b_parity, (c / 3 == 4) ? ^bw : 1'b0);
         tick();
      end
      check("b_idle_valid", b_out_valid, 0);
      check("b_idle_sel",   b_sel, 2'b01);
      check("b_idle_last",  b_out_last, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Watchdog so the bench always ends
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule : tb_mux4_serializer
`default_nettype wire

// File: doc/mux4_serializer.md
# mux4_serializer

Upstream sequencer for the 1-bit 4:1 mux cell (`Mux1bit4to1`). It accepts a 4-bit word over a valid/ready handshake and registers it onto the mux's four data inputs. It then steps the mux select through 00, 01, 10, 11, holding each value for a programmable number of cycles, so the mux output becomes a serial bit stream of the word, LSB first. Framing strobes mark valid and last bits for the consumer downstream of the mux.

## Interface
- `HOLD_CYCLES`, default 1: cycles each select value is held; legal range 1..255.
- `IDLE_SEL`, default 2'b00: value driven on `sel` while idle.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: synchronous, active-high reset. One clock domain; reset is sampled only on `clk` rising edge.
- `in_valid`  in  1: `in_data` offered.
- `in_ready`  out  1: word accepted on an edge where `in_valid && in_ready`.
- `in_data`  in  4: parallel word.
- `data1`..`data4`  out  1 each: registered word bits 0..3, to the mux data inputs.
- `sel`  out  2: mux select.
- `out_valid`  out  1: the mux output is a valid stream bit this cycle.
- `out_last`  out  1: this cycle is the final cycle of the final step of the frame.
- `busy`  out  1: a frame is in progress.
- `parity_out`  out  1: present only with `MUX4_SER_PARITY_EN`; see Configuration.

## Operation
- States:
  - IDLE: `sel`=`IDLE_SEL`, `out_valid`=0, `busy`=0.
  - SHIFT: step index `step` runs 0..3, `sel`=`step`.
  - PARITY: compiled only with `MUX4_SER_PARITY_EN`.
- IDLE to SHIFT on accept.
  - Capture `in_data[0..3]` into `data1..data4`.
  - Set `step`=0 and hold counter=0.
- In SHIFT:
  - Hold counter increments each cycle.
  - When it reaches `HOLD_CYCLES-1`, it clears and `step` increments.
  - After the final cycle of step 3, go to IDLE, or to PARITY when enabled.
- `in_ready`:
  - Asserted in IDLE.
  - Also asserted in the final cycle of the frame's last step. This allows back-to-back frames: an accept on that edge goes straight to SHIFT with step 0, with no idle gap.
  - Held 0 while `rst`=1.
- `data1..data4` stay stable for the whole frame and retain their values in IDLE. They change only on accept.
- `busy` = (state != IDLE).
- `out_valid` = `busy`.
- `out_last` = final step && hold counter == `HOLD_CYCLES-1`.
- Reset (also mid-frame): state=IDLE, `data1..4`=0, `sel`=`IDLE_SEL`, `out_valid`=`out_last`=`busy`=0, `parity_out`=0, counters=0. A partial frame is discarded with no `out_last`.
- `in_valid` while `in_ready`=0 is ignored, with no side effects. The source must hold its word.

## Timing
- All outputs except `in_ready` are registered.
- `in_ready` is combinational from state and counters only, never from `in_valid`.
- Accept at edge N: `data1..4`, `sel`=00, `out_valid`=1 visible after edge N.
- A frame lasts 4×`HOLD_CYCLES` cycles, or 5×`HOLD_CYCLES` with parity.
- Back-to-back throughput is one word per frame length.

## Configuration
- `MUX4_SER_PARITY_EN` defined:
  - Adds the `parity_out` port and the PARITY state, lasting `HOLD_CYCLES` cycles.
  - During PARITY: `sel` holds 2'b11, `out_valid`=1, and `parity_out`= even parity (XOR) of the captured word.
  - `out_last` and the back-to-back `in_ready` window move to the final PARITY cycle.
  - `parity_out` is 0 outside PARITY.
- Undefined: no `parity_out` port and no PARITY state. The frame ends after step 3.

## Structure
- Package `mux4_ser_pkg`:
  - State enum (IDLE, SHIFT, PARITY).
  - `NUM_STEPS`=4.
  - Hold-counter width function: $clog2 of `HOLD_CYCLES`, minimum 1.
- One sub-module, `hold_counter`:
  - Parameterised modulo-`HOLD_CYCLES` counter with clear and a terminal-count output.
  - Drives step advance and `out_last`.

## Test plan
- Reset: assert `rst` 2 cycles with `in_valid`=1 → all outputs 0, `sel`=`IDLE_SEL`, `in_ready`=0 during reset and 1 after.
- Single frame, `HOLD_CYCLES`=1, `in_data`=4'b1010:
  - `sel` 00,01,10,11 on 4 consecutive cycles.
  - `data1..4`=0,1,0,1.
  - Mux output stream 0,1,0,1.
  - `out_last` only on `sel`=11.
- Back-to-back: 4'b0011 then 4'b1100 offered on the `out_last` cycle → `sel` goes 11 to 00 with no gap and 8 contiguous `out_valid` cycles; stream 1,1,0,0,0,0,1,1.
- `HOLD_CYCLES`=3, 4'b0110 → each `sel` held 3 cycles, 12 `out_valid` cycles, `out_last` on cycle 12 only.
- Reset mid-frame at step 2 → next cycle IDLE, `out_valid`=0, no `out_last`; a new word is accepted normally afterwards.
- `MUX4_SER_PARITY_EN`, 4'b0111 → 5th step has `parity_out`=1 and `out_last`; with 4'b0101 → `parity_out`=0.
